// File: rtl/lohi_muldiv_if.sv
// Issue/result bus between the decode/execute stage and the LO/HI mul/div engine.
interface lohi_muldiv_if #(
    parameter int unsigned WIDTH = 16
);
    logic             start;
    logic [1:0]       op;
    logic [WIDTH-1:0] operand_a;
    logic [WIDTH-1:0] operand_b;
    logic             busy;
    logic             write_lo;
    logic             write_hi;
    logic [WIDTH-1:0] value_lo;
    logic [WIDTH-1:0] value_hi;
    logic             div_by_zero;

    // Issuing stage: drives the request, watches busy and the write strobes.
    modport master (
        output start, op, operand_a, operand_b,
        input  busy, write_lo, write_hi, value_lo, value_hi, div_by_zero
    );

    // Mul/div engine: consumes the request, produces the LO/HI write.
    modport slave (
        input  start, op, operand_a, operand_b,
        output busy, write_lo, write_hi, value_lo, value_hi, div_by_zero
    );
endinterface

// File: rtl/lohi_muldiv_unit.sv
// Iterative multiply/divide engine writing the LO/HI register pair.
// One iteration per cycle on sign-stripped magnitudes; sign fix-up in WRITE.
module lohi_muldiv_unit #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned CNT_W = 5
) (
    input  logic         clock,
    input  logic         reset,
    lohi_muldiv_if.slave bus
);
    localparam int unsigned PW = 2 * WIDTH;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        WRITE = 2'd2
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] counter;
    logic [1:0]       op_r;
    logic             sign_a_r;
    logic             sign_b_r;
    logic             dbz_r;
    logic [WIDTH-1:0] raw_a_r;
    logic [WIDTH:0]   mag_b_r;
    logic [PW-1:0]    acc_r;
    logic [PW-1:0]    mcand_r;
    logic [WIDTH-1:0] shreg_r;
    logic [WIDTH-1:0] rem_r;

    logic             in_signed_c;
    logic [WIDTH:0]   a_ext_c;
    logic [WIDTH:0]   b_ext_c;
    logic [WIDTH:0]   a_mag_c;
    logic [WIDTH:0]   b_mag_c;
    logic [WIDTH:0]   shifted_c;
    logic [WIDTH:0]   diff_c;
    logic             ge_c;
    logic             neg_c;
    logic [PW-1:0]    prod_fix_c;
    logic [WIDTH-1:0] quo_fix_c;
    logic [WIDTH-1:0] rem_fix_c;

    // Operand magnitudes on WIDTH+1 bits so the most negative value is exact.
    always_comb begin
        in_signed_c = bus.op[0];
        a_ext_c     = {in_signed_c & bus.operand_a[WIDTH-1], bus.operand_a};
        b_ext_c     = {in_signed_c & bus.operand_b[WIDTH-1], bus.operand_b};
        a_mag_c     = a_ext_c[WIDTH] ? -a_ext_c : a_ext_c;
        b_mag_c     = b_ext_c[WIDTH] ? -b_ext_c : b_ext_c;
    end

    // Restoring-divide trial subtraction and final sign fix-up.
    always_comb begin
        shifted_c  = {rem_r, shreg_r[WIDTH-1]};
        diff_c     = shifted_c - mag_b_r;
        ge_c       = (shifted_c >= mag_b_r);
        neg_c      = sign_a_r ^ sign_b_r;
        prod_fix_c = neg_c ? -acc_r : acc_r;
        quo_fix_c  = neg_c ? -shreg_r : shreg_r;
        rem_fix_c  = sign_a_r ? -rem_r : rem_r;
    end

    // Control FSM, datapath iteration and registered LO/HI write outputs.
    always_ff @(posedge clock) begin
        if (reset) begin
            state           <= IDLE;
            counter         <= '0;
            op_r            <= '0;
            sign_a_r        <= 1'b0;
            sign_b_r        <= 1'b0;
            dbz_r           <= 1'b0;
            raw_a_r         <= '0;
            mag_b_r         <= '0;
            acc_r           <= '0;
            mcand_r         <= '0;
            shreg_r         <= '0;
            rem_r           <= '0;
            bus.busy        <= 1'b0;
            bus.write_lo    <= 1'b0;
            bus.write_hi    <= 1'b0;
            bus.div_by_zero <= 1'b0;
            bus.value_lo    <= '0;
            bus.value_hi    <= '0;
        end else begin
            bus.write_lo    <= 1'b0;
            bus.write_hi    <= 1'b0;
            bus.div_by_zero <= 1'b0;
            case (state)
                IDLE: begin
                    bus.busy <= bus.start;
                    if (bus.start) begin
                        op_r     <= bus.op;
                        sign_a_r <= a_ext_c[WIDTH];
                        sign_b_r <= b_ext_c[WIDTH];
                        raw_a_r  <= bus.operand_a;
                        mag_b_r  <= b_mag_c;
                        acc_r    <= '0;
                        rem_r    <= '0;
                        counter  <= '0;
                        // Divide shifts the dividend out MSB first; multiply shifts the multiplier out LSB first.
                        if (bus.op[1]) begin
                            shreg_r <= a_mag_c[WIDTH-1:0];
                            mcand_r <= '0;
                        end else begin
                            shreg_r <= b_mag_c[WIDTH-1:0];
                            mcand_r <= PW'(a_mag_c);
                        end
                        if (bus.op[1] && (bus.operand_b == '0)) begin
                            dbz_r <= 1'b1;
                            state <= WRITE;
                        end else begin
                            dbz_r <= 1'b0;
                            state <= RUN;
                        end
                    end
                end
                RUN: begin
                    bus.busy <= 1'b1;
                    counter  <= counter + CNT_W'(1);
                    if (op_r[1]) begin
                        rem_r   <= ge_c ? diff_c[WIDTH-1:0] : shifted_c[WIDTH-1:0];
                        shreg_r <= {shreg_r[WIDTH-2:0], ge_c};
                    end else begin
                        acc_r   <= shreg_r[0] ? (acc_r + mcand_r) : acc_r;
                        mcand_r <= {mcand_r[PW-2:0], 1'b0};
                        shreg_r <= {1'b0, shreg_r[WIDTH-1:1]};
                    end
                    if (counter == CNT_W'(WIDTH - 1)) begin
                        state <= WRITE;
                    end
                end
                WRITE: begin
                    // Strobe cycle that follows still counts as busy.
                    bus.busy     <= 1'b1;
                    bus.write_lo <= 1'b1;
                    bus.write_hi <= 1'b1;
                    if (dbz_r) begin
                        bus.div_by_zero <= 1'b1;
                        bus.value_lo    <= '1;
                        bus.value_hi    <= raw_a_r;
                    end else if (op_r[1]) begin
                        bus.value_lo <= quo_fix_c;
                        bus.value_hi <= rem_fix_c;
                    end else begin
                        bus.value_lo <= prod_fix_c[WIDTH-1:0];
                        bus.value_hi <= prod_fix_c[PW-1:WIDTH];
                    end
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_lohi_muldiv_unit.sv
// Directed bench for lohi_muldiv_unit: hand-computed LO/HI results and exact strobe timing.
module tb_lohi_muldiv_unit;
    localparam logic [1:0] OP_MULTU = 2'b00;
    localparam logic [1:0] OP_MULT  = 2'b01;
    localparam logic [1:0] OP_DIVU  = 2'b10;
    localparam logic [1:0] OP_DIV   = 2'b11;

    logic clock;
    logic reset;
    int   checks;
    int   errors;
    int   nwrites;
    int   wr_at0;
    int   wr_at1;

    lohi_muldiv_if #(.WIDTH(16)) bus ();

    lohi_muldiv_unit #(.WIDTH(16), .CNT_W(5)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Pulse start for one edge (edge N); returns at the negedge following edge N.
    task automatic issue(input logic [1:0] o, input logic [15:0] a, input logic [15:0] b);
        @(negedge clock);
        bus.start     = 1'b1;
        bus.op        = o;
        bus.operand_a = a;
        bus.operand_b = b;
        @(negedge clock);
        bus.start     = 1'b0;
        bus.operand_a = 16'hDEAD;
        bus.operand_b = 16'hBEEF;
    endtask

    task automatic run_op(input string tag, input logic [1:0] o, input logic [15:0] a,
                          input logic [15:0] b, input logic [15:0] elo, input logic [15:0] ehi);
        issue(o, a, b);
        check({tag, " busy_set"}, 32'(bus.busy), 32'd1);
        repeat (16) @(negedge clock);
        check({tag, " no_early_write"}, 32'(bus.write_lo), 32'd0);
        @(negedge clock);
        check({tag, " write_lo"}, 32'(bus.write_lo), 32'd1);
        check({tag, " write_hi"}, 32'(bus.write_hi), 32'd1);
        check({tag, " value_lo"}, 32'(bus.value_lo), 32'(elo));
        check({tag, " value_hi"}, 32'(bus.value_hi), 32'(ehi));
        check({tag, " no_dbz"}, 32'(bus.div_by_zero), 32'd0);
        @(negedge clock);
        check({tag, " busy_clear"}, 32'(bus.busy), 32'd0);
        check({tag, " strobe_clear"}, 32'(bus.write_lo), 32'd0);
        check({tag, " value_hold"}, 32'(bus.value_lo), 32'(elo));
    endtask

    task automatic run_dbz(input string tag, input logic [1:0] o, input logic [15:0] a);
        issue(o, a, 16'h0000);
        check({tag, " busy_set"}, 32'(bus.busy), 32'd1);
        check({tag, " no_early_write"}, 32'(bus.write_lo), 32'd0);
        @(negedge clock);
        check({tag, " write_lo"}, 32'(bus.write_lo), 32'd1);
        check({tag, " write_hi"}, 32'(bus.write_hi), 32'd1);
        check({tag, " dbz"}, 32'(bus.div_by_zero), 32'd1);
        check({tag, " value_lo"}, 32'(bus.value_lo), 32'h0000_FFFF);
        check({tag, " value_hi"}, 32'(bus.value_hi), 32'(a));
        @(negedge clock);
        check({tag, " write_lo_clear"}, 32'(bus.write_lo), 32'd0);
        check({tag, " write_hi_clear"}, 32'(bus.write_hi), 32'd0);
        check({tag, " dbz_clear"}, 32'(bus.div_by_zero), 32'd0);
        check({tag, " busy_clear"}, 32'(bus.busy), 32'd0);
    endtask

    initial begin
        checks        = 0;
        errors        = 0;
        reset         = 1'b1;
        bus.start     = 1'b0;
        bus.op        = 2'b00;
        bus.operand_a = 16'h0000;
        bus.operand_b = 16'h0000;
        repeat (3) @(negedge clock);
        check("reset busy", 32'(bus.busy), 32'd0);
        check("reset write_lo", 32'(bus.write_lo), 32'd0);
        check("reset write_hi", 32'(bus.write_hi), 32'd0);
        check("reset dbz", 32'(bus.div_by_zero), 32'd0);
        check("reset value_lo", 32'(bus.value_lo), 32'd0);
        check("reset value_hi", 32'(bus.value_hi), 32'd0);
        reset = 1'b0;

        // 0xFFFF * 0xFFFF = 0xFFFE_0001
        run_op("multu_ffff", OP_MULTU, 16'hFFFF, 16'hFFFF, 16'h0001, 16'hFFFE);
        // -3 * 5 = -15
        run_op("mult_neg", OP_MULT, 16'hFFFD, 16'h0005, 16'hFFF1, 16'hFFFF);
        // -32768 * -32768 = 0x4000_0000
        run_op("mult_min", OP_MULT, 16'h8000, 16'h8000, 16'h0000, 16'h4000);
        // -7 / 2 = -3 rem -1
        run_op("div_neg", OP_DIV, 16'hFFF9, 16'h0002, 16'hFFFD, 16'hFFFF);
        // 100 / 7 = 14 rem 2
        run_op("divu_100_7", OP_DIVU, 16'd100, 16'd7, 16'd14, 16'd2);
        // -32768 / -1 overflows to 0x8000 rem 0
        run_op("div_ovf", OP_DIV, 16'h8000, 16'hFFFF, 16'h8000, 16'h0000);
        // 7 / -2 = -3 rem 1 (remainder follows dividend)
        run_op("div_negb", OP_DIV, 16'h0007, 16'hFFFE, 16'hFFFD, 16'h0001);

        run_dbz("divu_by0", OP_DIVU, 16'h1234);
        run_dbz("div_by0", OP_DIV, 16'hFFF0);

        // Second start during the run must be ignored.
        issue(OP_MULTU, 16'd3, 16'd4);
        nwrites = 0;
        wr_at0  = 0;
        for (int k = 1; k <= 24; k++) begin
            if (k == 5) begin
                bus.start     = 1'b1;
                bus.op        = OP_DIVU;
                bus.operand_a = 16'd9;
                bus.operand_b = 16'd3;
            end else begin
                bus.start = 1'b0;
            end
            @(negedge clock);
            if (bus.write_lo) begin
                nwrites++;
                wr_at0 = k;
            end
        end
        check("ignore_start writes", 32'(nwrites), 32'd1);
        check("ignore_start latency", 32'(wr_at0), 32'd17);
        check("ignore_start value_lo", 32'(bus.value_lo), 32'd12);
        check("ignore_start value_hi", 32'(bus.value_hi), 32'd0);

        // Start held high across the write: next op accepted in the strobe cycle.
        issue(OP_MULTU, 16'd2, 16'd5);
        bus.start     = 1'b1;
        bus.operand_a = 16'd2;
        bus.operand_b = 16'd5;
        nwrites = 0;
        wr_at0  = 0;
        wr_at1  = 0;
        for (int k = 1; k <= 40; k++) begin
            bus.start = (k <= 18);
            @(negedge clock);
            if (bus.write_lo) begin
                nwrites++;
                if (nwrites == 1) wr_at0 = k;
                else              wr_at1 = k;
            end
        end
        check("b2b writes", 32'(nwrites), 32'd2);
        check("b2b first", 32'(wr_at0), 32'd17);
        check("b2b second", 32'(wr_at1), 32'd35);
        check("b2b value_lo", 32'(bus.value_lo), 32'd10);

        // Reset in RUN cycle 8 aborts without a write strobe.
        issue(OP_MULT, 16'h0007, 16'h0003);
        repeat (7) @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        check("abort busy", 32'(bus.busy), 32'd0);
        check("abort write_lo", 32'(bus.write_lo), 32'd0);
        check("abort value_lo", 32'(bus.value_lo), 32'd0);
        reset   = 1'b0;
        nwrites = 0;
        for (int k = 1; k <= 24; k++) begin
            @(negedge clock);
            if (bus.write_lo || bus.write_hi) nwrites++;
        end
        check("abort no_write", 32'(nwrites), 32'd0);
        run_op("multu_after_abort", OP_MULTU, 16'd2, 16'd3, 16'd6, 16'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
